eeprom_ctrl: RTL and testbench

- Byte-level controller for the I2C EEPROM slave model.
- Sits between the I2C bit/byte front end and the page-organised storage array.
- Sequences word-address capture, page-write buffering with in-page rollover, and commit at STOP followed by a modelled tWR busy window.
- Serves sequential reads with an auto-incrementing address pointer.

---
 rtl/eeprom_pkg.sv | 19 +
 rtl/eeprom_ctrl_if.sv | 36 +++
 rtl/eeprom_page_buf.sv | 43 ++++
 rtl/eeprom_ctrl.sv | 164 ++++++++++++++++
 tb/tb_eeprom_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eeprom_pkg.sv
// rtl/eeprom_pkg.sv - shared state encoding and default constants for the EEPROM controller
package eeprom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_TWR    = 3'd4
  } state_t;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_PAGE_BYTES = 8;
  localparam int DEF_TWR_CYCLES = 64;

  // Byte returned to the master when it reads during a commit or tWR window
  localparam logic [7:0] BUSY_READ_BYTE = 8'hFF;

endpackage

// File: rtl/eeprom_ctrl_if.sv
// rtl/eeprom_ctrl_if.sv - front-end byte handshake and storage-array bus of the EEPROM controller
interface eeprom_ctrl_if #(
  parameter int ADDR_W = 8
) ();

  logic              i2c_start;
  logic              i2c_stop;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              ack_valid;
  logic              ack;
  logic              tx_req;
  logic              tx_valid;
  logic [7:0]        tx_byte;
  logic              busy;
  logic              mem_cs;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  // Front end and storage array side
  modport master (
    output i2c_start, i2c_stop, rx_valid, rx_byte, tx_req, mem_rdata,
    input  ack_valid, ack, tx_valid, tx_byte, busy,
    input  mem_cs, mem_write, mem_addr, mem_wdata
  );

  // Controller side
  modport slave (
    input  i2c_start, i2c_stop, rx_valid, rx_byte, tx_req, mem_rdata,
    output ack_valid, ack, tx_valid, tx_byte, busy,
    output mem_cs, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/eeprom_page_buf.sv
// rtl/eeprom_page_buf.sv - page write buffer with per-byte dirty bits for the commit scan
module eeprom_page_buf #(
  parameter int PAGE_BYTES = 8,
  parameter int OFF_W      = $clog2(PAGE_BYTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [7:0]       wr_data,
  input  logic             clear,
  input  logic [OFF_W-1:0] rd_off,
  output logic [7:0]       rd_data,
  output logic             rd_dirty,
  output logic             any_dirty
);

  logic [7:0]            data_q [PAGE_BYTES];
  logic [PAGE_BYTES-1:0] dirty_q;

  // Byte storage; contents are only meaningful where the dirty bit is set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PAGE_BYTES; i++) data_q[i] <= '0;
    end else if (wr_en) begin
      data_q[wr_off] <= wr_data;
    end
  end

  // Dirty bits; clear wins over a same-cycle write so a discard is total
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      dirty_q <= '0;
    end else if (wr_en) begin
      dirty_q[wr_off] <= 1'b1;
    end
  end

  assign rd_data   = data_q[rd_off];
  assign rd_dirty  = dirty_q[rd_off];
  assign any_dirty = |dirty_q;

endmodule

// File: rtl/eeprom_ctrl.sv
// rtl/eeprom_ctrl.sv - EEPROM byte controller top; optional EEPROM_WP_EN adds the wp write-protect input
module eeprom_ctrl
  import eeprom_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int PAGE_BYTES = DEF_PAGE_BYTES,
  parameter int TWR_CYCLES = DEF_TWR_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
`ifdef EEPROM_WP_EN
  input  logic wp,
`endif
  eeprom_ctrl_if.slave bus
);

  localparam int              OFF_W     = $clog2(PAGE_BYTES);
  localparam int              TWR_W     = $clog2(TWR_CYCLES + 1);
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_BYTES - 1);

  state_t            state, next_state;
  logic [ADDR_W-1:0] ptr_q;
  logic [OFF_W-1:0]  scan_q;
  logic [TWR_W-1:0]  twr_q;

  logic              wp_act;
  logic              busy_st;
  logic              scan_last;
  logic              twr_last;
  logic              wr_en;
  logic              rx_accept;
  logic              tx_serve;
  logic              tx_busy;
  logic              buf_clear;
  logic [7:0]        buf_rd_data;
  logic              buf_rd_dirty;
  logic              buf_any_dirty;
  logic [ADDR_W-1:0] ptr_page_inc;
  logic [ADDR_W-1:0] page_base;

`ifdef EEPROM_WP_EN
  assign wp_act = wp;
`else
  assign wp_act = 1'b0;
`endif

  assign busy_st   = (state == ST_COMMIT) || (state == ST_TWR);
  assign scan_last = (scan_q == OFF_W'(PAGE_BYTES - 1));
  assign twr_last  = (twr_q == TWR_W'(TWR_CYCLES - 1));
  assign wr_en     = (state == ST_DATA) && bus.rx_valid && !wp_act;
  assign rx_accept = bus.rx_valid &&
                     ((state == ST_ADDR) || ((state == ST_DATA) && !wp_act));
  // A received byte always takes the cycle; a colliding read request is dropped
  assign tx_serve  = bus.tx_req && !bus.rx_valid &&
                     ((state == ST_IDLE) || (state == ST_ADDR));
  assign tx_busy   = bus.tx_req && !bus.rx_valid && busy_st;

  // Writes wrap inside the current page; reads wrap over the whole array
  assign ptr_page_inc = (ptr_q & ~PAGE_MASK) | ((ptr_q + ADDR_W'(1)) & PAGE_MASK);
  assign page_base    = ptr_q & ~PAGE_MASK;

  // Leaving DATA without committing, or finishing a commit, empties the buffer
  assign buf_clear = ((state == ST_DATA) &&
                      ((next_state == ST_IDLE) || (next_state == ST_ADDR))) ||
                     ((state == ST_COMMIT) && (next_state == ST_TWR));

  eeprom_page_buf #(
    .PAGE_BYTES (PAGE_BYTES),
    .OFF_W      (OFF_W)
  ) u_page_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_off    (ptr_q[OFF_W-1:0]),
    .wr_data   (bus.rx_byte),
    .clear     (buf_clear),
    .rd_off    (scan_q),
    .rd_data   (buf_rd_data),
    .rd_dirty  (buf_rd_dirty),
    .any_dirty (buf_any_dirty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; a byte arriving with STOP counts toward the dirty check
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (bus.i2c_start) next_state = ST_ADDR;
      end
      ST_ADDR: begin
        if (bus.i2c_stop)      next_state = ST_IDLE;
        else if (bus.rx_valid) next_state = ST_DATA;
      end
      ST_DATA: begin
        if (bus.i2c_stop) begin
          if ((buf_any_dirty || wr_en) && !wp_act) next_state = ST_COMMIT;
          else                                     next_state = ST_IDLE;
        end else if (bus.i2c_start) begin
          next_state = ST_ADDR;
        end
      end
      ST_COMMIT: begin
        if (scan_last) next_state = ST_TWR;
      end
      ST_TWR: begin
        if (twr_last) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Storage bus drive: commit scan writes dirty offsets, reads address the pointer
  always_comb begin
    bus.mem_cs    = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = busy_st;
    if (rst_n) begin
      if ((state == ST_COMMIT) && buf_rd_dirty) begin
        bus.mem_cs    = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = page_base | ADDR_W'(scan_q);
        bus.mem_wdata = buf_rd_data;
      end else if (tx_serve) begin
        bus.mem_cs   = 1'b1;
        bus.mem_addr = ptr_q;
      end
    end
  end

  // Pointer, scan/tWR counters and registered handshake responses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      scan_q        <= '0;
      twr_q         <= '0;
      bus.ack_valid <= 1'b0;
      bus.ack       <= 1'b0;
      bus.tx_valid  <= 1'b0;
      bus.tx_byte   <= '0;
    end else begin
      bus.ack_valid <= bus.rx_valid;
      bus.ack       <= rx_accept;
      bus.tx_valid  <= tx_serve || tx_busy;
      if (tx_busy)       bus.tx_byte <= BUSY_READ_BYTE;
      else if (tx_serve) bus.tx_byte <= bus.mem_rdata;

      if ((state == ST_ADDR) && bus.rx_valid) ptr_q <= ADDR_W'(bus.rx_byte);
      else if (wr_en)                         ptr_q <= ptr_page_inc;
      else if (tx_serve)                      ptr_q <= ptr_q + ADDR_W'(1);

      scan_q <= (state == ST_COMMIT) ? scan_q + OFF_W'(1) : '0;
      twr_q  <= ((state == ST_TWR) && !twr_last) ? twr_q + TWR_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_eeprom_ctrl.sv
// tb/tb_eeprom_ctrl.sv - self-checking bench for eeprom_ctrl against an array-level reference model
module tb_eeprom_ctrl;
  import eeprom_pkg::*;

  localparam int AW  = 8;
  localparam int PB  = 8;
  localparam int TWR = 64;
  localparam int NB  = 256;
  localparam int BUSY_LEN = PB + TWR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eeprom_ctrl_if #(.ADDR_W(AW)) bus ();

`ifdef EEPROM_WP_EN
  logic wp = 1'b0;
`endif

  eeprom_ctrl #(
    .ADDR_W     (AW),
    .PAGE_BYTES (PB),
    .TWR_CYCLES (TWR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef EEPROM_WP_EN
    .wp    (wp),
`endif
    .bus   (bus)
  );

  logic [7:0] store [NB];
  logic [7:0] seed [NB];
  logic [7:0] ref_mem [NB];
  logic       load = 1'b0;
  int         wr_count = 0;
  int         ref_ptr = 0;
  int         exp_writes = 0;
  logic [7:0] q_data [$];
  int         n_assert = 0;
  int         n_fail = 0;

  // Storage array: combinational read, write on the clock edge
  assign bus.mem_rdata = store[bus.mem_addr];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NB; i++) store[i] <= seed[i];
    end else if (bus.mem_cs && bus.mem_write) begin
      store[bus.mem_addr] <= bus.mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < NB; i++) if (store[i] !== ref_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic pulse_start();
    bus.i2c_start = 1'b1; cyc(); bus.i2c_start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.i2c_stop = 1'b1; cyc(); bus.i2c_stop = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    bus.rx_valid = 1'b1; bus.rx_byte = b;
    cyc();
    bus.rx_valid = 1'b0;
    chk({tag, "_valid"}, bus.ack_valid, 1);
    chk(tag, bus.ack, exp_ack);
  endtask

  task automatic do_read(input string tag);
    bus.tx_req = 1'b1;
    #1;
    chk({tag, "_rdbus"}, {bus.mem_cs, bus.mem_write}, 2'b10);
    chk({tag, "_addr"}, bus.mem_addr, ref_ptr);
    cyc();
    bus.tx_req = 1'b0;
    chk({tag, "_valid"}, bus.tx_valid, 1);
    chk(tag, bus.tx_byte, ref_mem[ref_ptr]);
    ref_ptr = (ref_ptr + 1) % NB;
  endtask

  // Bounded count of consecutive busy cycles starting now
  task automatic busy_len(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 500) begin
      n++;
      cyc();
    end
  endtask

  // Reference: a page write lands each byte at (addr+i) mod page, last one wins
  task automatic model_commit(input int a);
    logic [7:0] pbuf [PB];
    bit         pd [PB];
    int         base;
    base = a & ~(PB - 1);
    for (int o = 0; o < PB; o++) pd[o] = 1'b0;
    for (int i = 0; i < q_data.size(); i++) begin
      pbuf[(a + i) % PB] = q_data[i];
      pd[(a + i) % PB]   = 1'b1;
    end
    exp_writes = 0;
    for (int o = 0; o < PB; o++) if (pd[o]) begin
      ref_mem[base + o] = pbuf[o];
      exp_writes++;
    end
    ref_ptr = (q_data.size() == 0) ? a : base + ((a + q_data.size()) % PB);
  endtask

  task automatic do_write(input int a, input string tag);
    int w0;
    int n;
    pulse_start();
    send_byte(8'(a), 1'b1, {tag, "_addr_ack"});
    foreach (q_data[i]) send_byte(q_data[i], 1'b1, {tag, "_data_ack"});
    w0 = wr_count;
    pulse_stop();
    model_commit(a);
    busy_len(n);
    chk({tag, "_busy_len"}, n, (q_data.size() > 0) ? BUSY_LEN : 0);
    cyc();
    chk({tag, "_writes"}, wr_count - w0, exp_writes);
    chk_mem({tag, "_mem"});
  endtask

  initial begin
    int w0;
    int n;
    int a;
    int len;

    bus.i2c_start = 1'b0; bus.i2c_stop = 1'b0;
    bus.rx_valid  = 1'b0; bus.rx_byte  = '0;
    bus.tx_req    = 1'b0;
    for (int i = 0; i < NB; i++) begin
      seed[i]    = 8'($urandom);
      ref_mem[i] = seed[i];
    end
    seed[8'h10] = 8'h00;
    ref_mem[8'h10] = 8'h00;

    rst_n = 1'b0; load = 1'b1;
    repeat (3) cyc();
    load = 1'b0;
    chk("rst_ack_valid", bus.ack_valid, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_byte", bus.tx_byte, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_bus", {bus.mem_cs, bus.mem_write, bus.mem_addr, bus.mem_wdata}, 0);
    rst_n = 1'b1;
    cyc();

    send_byte(8'h3C, 1'b0, "idle_nack");

    q_data = {8'hA5};
    do_write(8'h10, "single");
    chk("single_byte", store[8'h10], 8'hA5);

    q_data = {8'h01, 8'h02, 8'h03, 8'h04};
    do_write(8'h0E, "rollover");
    chk("rollover_08", store[8'h08], 8'h03);
    chk("rollover_10", store[8'h10], 8'hA5);
    chk("rollover_ptr", ref_ptr, 8'h0A);
    do_read("rollover_ptr_rd");

    q_data = {};
    do_write(8'h10, "dummy");
    chk("dummy_busy", bus.busy, 0);
    w0 = wr_count;
    do_read("rand_rd0");
    do_read("rand_rd1");
    do_read("rand_rd2");
    chk("rand_rd_nowrite", wr_count - w0, 0);

    q_data = {8'hC3};
    pulse_start();
    send_byte(8'h50, 1'b1, "busy_addr_ack");
    send_byte(8'hC3, 1'b1, "busy_data_ack");
    w0 = wr_count;
    pulse_stop();
    repeat (20) cyc();
    chk("busy_in_twr", bus.busy, 1);
    send_byte(8'h77, 1'b0, "busy_nack");
    bus.tx_req = 1'b1; cyc(); bus.tx_req = 1'b0;
    chk("busy_rd_valid", bus.tx_valid, 1);
    chk("busy_rd_ff", bus.tx_byte, 8'hFF);
    pulse_start();
    pulse_stop();
    busy_len(n);
    chk("busy_end", bus.busy, 0);
    send_byte(8'h12, 1'b0, "busy_start_ignored");
    chk("busy_writes", wr_count - w0, 1);
    model_commit(8'h50);
    chk_mem("busy_mem");
    do_read("busy_ptr_rd");

    w0 = wr_count;
    pulse_start();
    send_byte(8'h20, 1'b1, "rs_addr_ack");
    send_byte(8'hDE, 1'b1, "rs_d0_ack");
    send_byte(8'hAD, 1'b1, "rs_d1_ack");
    pulse_start();
    send_byte(8'h30, 1'b1, "rs_readdr_ack");
    pulse_stop();
    chk("rs_busy", bus.busy, 0);
    repeat (PB + 2) cyc();
    chk("rs_writes", wr_count - w0, 0);
    q_data = {};
    model_commit(8'h30);
    chk_mem("rs_mem");
    do_read("rs_ptr_rd");

    pulse_start();
    send_byte(8'h60, 1'b1, "rxstop_addr_ack");
    w0 = wr_count;
    bus.rx_valid = 1'b1; bus.rx_byte = 8'h5A; bus.i2c_stop = 1'b1;
    cyc();
    bus.rx_valid = 1'b0; bus.i2c_stop = 1'b0;
    chk("rxstop_ack", {bus.ack_valid, bus.ack}, 2'b11);
    busy_len(n);
    chk("rxstop_busy_len", n, BUSY_LEN);
    q_data = {8'h5A};
    model_commit(8'h60);
    chk("rxstop_writes", wr_count - w0, exp_writes);
    chk_mem("rxstop_mem");

    q_data = {};
    do_write(8'hFE, "wrap");
    do_read("wrap_fe");
    do_read("wrap_ff");
    do_read("wrap_00");

    q_data = {8'h11, 8'h22, 8'h33, 8'h44};
    pulse_start();
    send_byte(8'h40, 1'b1, "rstc_addr_ack");
    foreach (q_data[i]) send_byte(q_data[i], 1'b1, "rstc_data_ack");
    w0 = wr_count;
    pulse_stop();
    repeat (3) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rstc_busy", bus.busy, 0);
    chk("rstc_outputs", {bus.mem_cs, bus.mem_write, bus.ack_valid, bus.tx_valid}, 0);
    cyc();
    chk("rstc_writes", wr_count - w0, 3);
    for (int i = 0; i < 3; i++) ref_mem[8'h40 + i] = q_data[i];
    ref_ptr = 0;
    chk_mem("rstc_mem");
    do_read("rstc_ptr_rd");

    for (int t = 0; t < 16; t++) begin
      a   = int'($urandom_range(0, NB - 1));
      len = int'($urandom_range(0, 10));
      q_data = {};
      for (int i = 0; i < len; i++) q_data.push_back(8'($urandom));
      do_write(a, "rnd_wr");
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) do_read("rnd_rd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
